// File: rtl/prio_enc_pipe_if.sv
// Bundle of the request and result handshake signals of prio_enc_pipe.
// The slave modport is the encoder. The master modport is whoever produces
// requests and consumes results.
//
// Handshake rules, for both sides:
//   - A transfer happens on a rising clk edge where valid and ready are both high.
//   - A producer holds its valid and data stable until the transfer happens.
//   - in_ready may depend combinationally on out_ready. This lets a full
//     stage refill in the same cycle it drains.
interface prio_enc_pipe_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] Y;
  logic [N-1:0]     grant;
  logic             valid;
  logic [IDX_W:0]   cnt;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  req, in_valid, out_ready,
    output in_ready, Y, grant, valid, cnt, out_valid
  );

  modport master (
    output req, in_valid, out_ready,
    input  in_ready, Y, grant, valid, cnt, out_valid
  );
endinterface

// File: rtl/prio_enc_pipe.sv
// One-stage pipelined priority encoder with a population count.
// Each accepted request vector produces one result:
//   - Y: the index of the winning request.
//   - grant: the one-hot form of Y.
//   - valid: high when any request bit was set.
//   - cnt: the number of set request bits.
// By default the priority is fixed, and the highest set index wins.
// Defining the macro PRIO_ENC_RR_EN switches to round-robin priority. In that
// mode the search starts at the register ptr and moves downward, wrapping around.
module prio_enc_pipe #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  prio_enc_pipe_if.slave   bus,
  output logic             dbg_state,
  output logic [IDX_W-1:0] dbg_ptr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] y_q;
  logic [N-1:0]     grant_q;
  logic             valid_q;
  logic [IDX_W:0]   cnt_q;

  logic             in_hs;
  logic [IDX_W-1:0] ptr_cur;
  logic             found;
  logic [IDX_W-1:0] win;
  int               idx_i;
  logic [N-1:0]     grant_nxt;
  logic [IDX_W:0]   cnt_nxt;

  // A full stage can still accept a new vector when its result leaves this cycle.
  assign bus.in_ready = (state == EMPTY) || bus.out_ready;
  assign in_hs        = bus.in_valid && bus.in_ready;

  // Search from ptr_cur downward, wrapping from 0 to N-1; the first set bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_i = 0;
    for (int k = 0; k < N; k++) begin
      idx_i = int'(ptr_cur) - k;
      if (idx_i < 0) idx_i = idx_i + N;
      if (!found && bus.req[idx_i]) begin
        found = 1'b1;
        win   = IDX_W'(idx_i);
      end
    end
  end

  // Count every set request bit, regardless of priority.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nxt = cnt_nxt + (IDX_W+1)'(bus.req[i]);
    end
  end

  // Build the one-hot grant; it is all zeros when no request bit is set.
  always_comb begin
    grant_nxt = '0;
    if (found) grant_nxt = N'(1) << win;
  end

`ifdef PRIO_ENC_RR_EN
  logic [IDX_W-1:0] ptr_q;

  // After a win, ptr moves just below the winner so that bit has lowest priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(N-1);
    end else if (in_hs && found) begin
      ptr_q <= (win == '0) ? IDX_W'(N-1) : win - IDX_W'(1);
    end
  end

  assign ptr_cur = ptr_q;
`else
  // Fixed priority is round-robin with the pointer held at the top bit.
  assign ptr_cur = IDX_W'(N-1);
`endif

  // Output stage FSM and result registers. Results only change on an accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      y_q     <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (in_hs) begin
        state   <= FULL;
        y_q     <= win;
        grant_q <= grant_nxt;
        valid_q <= found;
        cnt_q   <= cnt_nxt;
      end else if (state == FULL && bus.out_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.Y         = y_q;
  assign bus.grant     = grant_q;
  assign bus.valid     = valid_q;
  assign bus.cnt       = cnt_q;

  assign dbg_state = state;
  assign dbg_ptr   = ptr_cur;

endmodule

// File: doc/prio_enc_pipe.md
PRIO_ENC_PIPE -- requirements
Module: prio_enc_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8, number of request inputs (N >= 2).
REQ-002 The block SHALL have parameter IDX_W, default 3, index width, equal to ceil(log2(N)).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, N, the request vector, sampled on an input handshake.
REQ-006 The block SHALL have port in_valid, input, 1, meaning req holds a vector to encode.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts req this cycle.
REQ-008 The block SHALL have port Y, output, IDX_W, the encoded index of the winning request.
REQ-009 The block SHALL have port grant, output, N, the one-hot form of Y; all zeros when no request won.
REQ-010 The block SHALL have port valid, output, 1, high when the captured req had at least one bit set.
REQ-011 The block SHALL have port cnt, output, IDX_W+1, the number of set bits in the captured req.
REQ-012 The block SHALL have port out_valid, output, 1, meaning Y, grant, valid and cnt hold a result.
REQ-013 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.

Function
REQ-014 The block SHALL have a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 in_ready SHALL equal (state==EMPTY) or out_ready, combinationally.
REQ-016 An input handshake SHALL occur when in_valid and in_ready are both high at a rising clk edge.
REQ-017 On an input handshake the block SHALL register Y, grant, valid and cnt computed from req, and enter FULL; latency is 1 cycle.
REQ-018 In FULL with out_ready=1 and no input handshake, the block SHALL go to EMPTY; the result registers SHALL hold their values.
REQ-019 In FULL with out_ready=1 and in_valid=1, the block SHALL stay FULL and load the new result in the same cycle (back-to-back, one result per cycle).
REQ-020 In FULL with out_ready=0, the block SHALL hold Y, grant, valid and cnt stable, and in_ready SHALL be 0.
REQ-021 Fixed priority SHALL make the highest set index win (bit N-1 highest).
REQ-022 For req all zeros, the result SHALL be Y=0, grant=0, valid=0, cnt=0, and out_valid SHALL still assert (an empty result is a legal result).
REQ-023 cnt SHALL count all set bits regardless of priority, so cnt=N is representable.

Reset
REQ-024 While rst_n=0, the block SHALL hold state=EMPTY, out_valid=0, Y=0, grant=0, valid=0, cnt=0, and (RR_EN) ptr=N-1, all asynchronously.
REQ-025 A reset asserted mid-transaction SHALL discard the pending result; no handshake SHALL complete on the edge where rst_n is low.
REQ-026 After rst_n deasserts, in_ready SHALL be 1 from the first cycle.

Configuration
REQ-027 Macro PRIO_ENC_RR_EN, when defined, SHALL enable round-robin priority using an IDX_W-bit register ptr.
REQ-028 With PRIO_ENC_RR_EN defined, the search SHALL start at ptr and descend with wrap-around (ptr, ptr-1, ..., 0, N-1, ..., ptr+1); the first set bit wins.
REQ-029 With PRIO_ENC_RR_EN defined, on an input handshake with valid=1, ptr SHALL become Y-1, or N-1 when Y=0; ptr SHALL be unchanged otherwise.
REQ-030 Without PRIO_ENC_RR_EN, fixed priority per REQ-021 SHALL apply, no ptr register SHALL exist, and behaviour SHALL equal RR mode with ptr held at N-1.

Verification
REQ-031 Reset, then req=8'h00 in one handshake -> next cycle out_valid=1, valid=0, Y=0, grant=0, cnt=0.
REQ-032 Walk a one through req bits 0..7 with out_ready=1 -> Y=0..7, grant=req, cnt=1, one result per cycle.
REQ-033 Fixed priority: req=8'b10101010 -> Y=7, cnt=4; req=8'b00110011 -> Y=5, cnt=4; req=8'hFF -> cnt=8.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; release -> the second vector appears on the next cycle with no loss or duplication.
REQ-035 PRIO_ENC_RR_EN: issue req=8'hFF four times -> Y=7,6,5,4; then req=8'b10000001 -> Y=0, then ptr=7.
REQ-036 Assert rst_n=0 while FULL with out_ready=0 -> out_valid drops immediately without a clk edge, and ptr returns to 7.
